rv32_div_iter: RTL and testbench

//  Iterative radix-2 divider for the RV32M DIV/DIVU/REM/REMU ops.

---
 rtl/rv32_mext_pkg.sv | 15 +
 rtl/rv32_div_iter_if.sv | 24 ++
 rtl/rv32_div_iter.sv | 70 +++++++
 tb/tb_rv32_div_iter.sv | 148 ++++++++++++++
 4 files changed

// File: rtl/rv32_mext_pkg.sv
// rv32_mext_pkg: RV32M divide op encodings, divider FSM states and XLEN shared with Mul_Div
package rv32_mext_pkg;
  localparam int XLEN = 32;
  typedef enum logic [1:0] {
    OP_DIV  = 2'b00,
    OP_DIVU = 2'b01,
    OP_REM  = 2'b10,
    OP_REMU = 2'b11
  } op_e;
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    DONE = 2'b10
  } state_e;
endpackage

// File: rtl/rv32_div_iter_if.sv
// rv32_div_iter_if: request/result handshake between Mul_Div, the divider and writeback
interface rv32_div_iter_if #(parameter int TAG_W = 5);
  import rv32_mext_pkg::*;
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       op;
  logic [XLEN-1:0]  rs1;
  logic [XLEN-1:0]  rs2;
  logic [TAG_W-1:0] rd_tag;
  logic             flush;
  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  result;
  logic [TAG_W-1:0] out_tag;
  logic             busy;
  modport master (
    output in_valid, op, rs1, rs2, rd_tag, flush, out_ready,
    input  in_ready, out_valid, result, out_tag, busy
  );
  modport slave (
    input  in_valid, op, rs1, rs2, rd_tag, flush, out_ready,
    output in_ready, out_valid, result, out_tag, busy
  );
endinterface

// File: rtl/rv32_div_iter.sv
// rv32_div_iter: iterative radix-2 restoring divider for DIV/DIVU/REM/REMU
module rv32_div_iter
  import rv32_mext_pkg::*;
(
  input logic           clk,
  input logic           rst_n,
  rv32_div_iter_if.slave d
);
  state_e          state, state_n;
  logic [XLEN-1:0] rem, quo, dvs, a, b, nrem, nquo, fix;
  logic [XLEN:0]   trial, diff;
  logic [4:0]      cnt;
  logic            run, is_rem, neg_q, neg_r, sgn, acc, div0, ovf, last;
  always_comb begin
    sgn   = d.op == OP_DIV || d.op == OP_REM;
    a     = sgn && d.rs1[XLEN-1] ? -d.rs1 : d.rs1;
    b     = sgn && d.rs2[XLEN-1] ? -d.rs2 : d.rs2;
    acc   = d.in_valid & d.in_ready & ~d.flush;
    div0  = d.rs2 == '0;
    ovf   = sgn && d.rs1 == 32'h8000_0000 && d.rs2 == 32'hFFFF_FFFF;
    trial = {rem, quo[XLEN-1]};
    diff  = trial - {1'b0, dvs};
    nrem  = diff[XLEN] ? trial[XLEN-1:0] : diff[XLEN-1:0];
    nquo  = {quo[XLEN-2:0], ~diff[XLEN]};
    fix   = is_rem ? (neg_r ? -nrem : nrem) : (neg_q ? -nquo : nquo);
    last  = run && cnt == 5'd31;
  end
  always_ff @(posedge clk)
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  always_comb begin
    state_n = d.flush         ? IDLE :
              state == IDLE   ? (acc ? (div0 || ovf ? DONE : CALC) : IDLE) :
              state == CALC   ? (last ? DONE : CALC) :
              d.out_ready     ? IDLE : DONE;
  end
  always_comb begin
    d.in_ready  = state == IDLE;
    d.busy      = state != IDLE;
    d.out_valid = state == DONE;
  end
  // one settling cycle after accept before the first of 32 iterations
  always_ff @(posedge clk)
    if (!rst_n) begin
      d.result  <= '0;
      d.out_tag <= '0;
      run       <= 1'b0;
      cnt       <= '0;
    end else if (acc) begin
      d.out_tag <= d.rd_tag;
      is_rem    <= d.op[1];
      neg_q     <= sgn & (d.rs1[XLEN-1] ^ d.rs2[XLEN-1]);
      neg_r     <= sgn & d.rs1[XLEN-1];
      rem       <= '0;
      quo       <= a;
      dvs       <= b;
      cnt       <= '0;
      run       <= 1'b0;
      if (div0)     d.result <= d.op[1] ? d.rs1 : 32'hFFFF_FFFF;
      else if (ovf) d.result <= d.op[1] ? 32'h0 : 32'h8000_0000;
    end else if (state == CALC) begin
      run <= 1'b1;
      if (run) begin
        rem <= nrem;
        quo <= nquo;
        cnt <= cnt + 5'd1;
      end
      if (last) d.result <= fix;
    end
endmodule

// File: tb/tb_rv32_div_iter.sv
// tb_rv32_div_iter: directed and random checks of the iterative divider against an arithmetic model
module tb_rv32_div_iter;
  import rv32_mext_pkg::*;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;
  rv32_div_iter_if #(.TAG_W(5)) d();
  rv32_div_iter u (.clk(clk), .rst_n(rst_n), .d(d));
  always #5 clk = ~clk;

  function automatic logic [31:0] model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    if (y == 32'd0) return o[1] ? x : 32'hFFFF_FFFF;
    if (!o[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return o[1] ? 32'd0 : 32'h8000_0000;
    case (o)
      OP_DIV:  return $signed(x) / $signed(y);
      OP_DIVU: return x / y;
      OP_REM:  return $signed(x) % $signed(y);
      default: return x % y;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y, input logic [4:0] t);
    d.in_valid = 1'b1;
    d.op = o;
    d.rs1 = x;
    d.rs2 = y;
    d.rd_tag = t;
    check("in_ready before accept", {31'd0, d.in_ready}, 32'd1);
    step();
    d.in_valid = 1'b0;
    d.op = 2'($urandom);
    d.rs1 = $urandom;
    d.rs2 = $urandom;
    d.rd_tag = 5'($urandom);
  endtask

  task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                        input logic [4:0] t, input int hold);
    logic [31:0] e;
    int cyc;
    bit sp;
    e = model(o, x, y);
    sp = y == 32'd0 || (!o[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF);
    issue(o, x, y, t);
    cyc = 0;
    while (!d.out_valid && cyc < 100) begin
      step();
      cyc++;
    end
    check({tag, " latency"}, cyc, sp ? 32'd0 : 32'd33);
    check({tag, " result"}, d.result, e);
    check({tag, " out_tag"}, {27'd0, d.out_tag}, {27'd0, t});
    for (int i = 0; i < hold; i++) begin
      step();
      check({tag, " held result"}, d.result, e);
      check({tag, " held out_tag"}, {27'd0, d.out_tag}, {27'd0, t});
      check({tag, " held valid/ready/busy"}, {29'd0, d.out_valid, d.in_ready, d.busy}, 32'b101);
    end
    d.out_ready = 1'b1;
    step();
    d.out_ready = 1'b0;
    check({tag, " idle after handshake"}, {29'd0, d.out_valid, d.in_ready, d.busy}, 32'b010);
  endtask

  task automatic kill(input string tag, input bit use_rst);
    int seen;
    seen = 0;
    issue(OP_DIVU, 32'd1000, 32'd7, 5'd9);
    repeat (10) step();
    if (use_rst) rst_n = 1'b0;
    else d.flush = 1'b1;
    step();
    rst_n = 1'b1;
    d.flush = 1'b0;
    check({tag, " in_ready/busy after kill"}, {30'd0, d.in_ready, d.busy}, 32'b10);
    for (int i = 0; i < 40; i++) begin
      if (d.out_valid) seen++;
      step();
    end
    check({tag, " no out_valid after kill"}, seen, 32'd0);
    run_op({tag, " then DIVU 9/3"}, OP_DIVU, 32'd9, 32'd3, 5'd4, 0);
  endtask

  initial begin
    logic [1:0]  o;
    logic [31:0] x, y;
    int r;
    d.in_valid = 1'b0;
    d.op = 2'b00;
    d.rs1 = '0;
    d.rs2 = '0;
    d.rd_tag = '0;
    d.flush = 1'b0;
    d.out_ready = 1'b0;
    step();
    step();
    check("reset out_valid/in_ready/busy", {29'd0, d.out_valid, d.in_ready, d.busy}, 32'b010);
    check("reset result", d.result, 32'd0);
    check("reset out_tag", {27'd0, d.out_tag}, 32'd0);
    rst_n = 1'b1;
    step();
    run_op("DIVU 100/7", OP_DIVU, 32'd100, 32'd7, 5'd3, 0);
    run_op("REMU 100/7", OP_REMU, 32'd100, 32'd7, 5'd5, 0);
    run_op("DIV -7/2", OP_DIV, 32'hFFFF_FFF9, 32'd2, 5'd6, 0);
    run_op("REM -7/2", OP_REM, 32'hFFFF_FFF9, 32'd2, 5'd7, 0);
    run_op("REM 7/-2", OP_REM, 32'd7, 32'hFFFF_FFFE, 5'd8, 0);
    run_op("DIVU 5/0", OP_DIVU, 32'd5, 32'd0, 5'd10, 0);
    run_op("REM 5/0", OP_REM, 32'd5, 32'd0, 5'd11, 0);
    run_op("DIV ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12, 0);
    run_op("REM ovf", OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 5'd13, 0);
    run_op("DIVU hold", OP_DIVU, 32'hDEAD_BEEF, 32'd12345, 5'd31, 5);
    d.in_valid = 1'b1;
    d.op = OP_DIVU;
    d.rs1 = 32'd50;
    d.rs2 = 32'd5;
    d.flush = 1'b1;
    step();
    d.in_valid = 1'b0;
    d.flush = 1'b0;
    check("flush with in_valid no accept", {30'd0, d.in_ready, d.busy}, 32'b10);
    kill("flush", 1'b0);
    kill("reset", 1'b1);
    for (int k = 0; k < 30; k++) begin
      o = 2'($urandom);
      x = $urandom;
      r = $urandom_range(0, 9);
      y = r == 0 ? 32'd0 : r == 1 ? 32'hFFFF_FFFF : r == 2 ? 32'($urandom_range(1, 15)) : $urandom;
      if (r == 1 && k[0]) x = 32'h8000_0000;
      run_op($sformatf("rand%0d op%0d %h/%h", k, o, x, y), o, x, y, 5'($urandom), $urandom_range(0, 2));
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
